// File: rtl/mdu_ctrl.sv
// HI/LO multiply-divide sequencer for the E stage: latches the result at issue,
// holds busy for a fixed latency, then commits to HI/LO.
module mdu_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        cancel,
    output logic        busy,
    output logic        hilo_busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    logic        state;
    logic [3:0]  cnt;
    logic [31:0] p_hi;
    logic [31:0] p_lo;
    logic        inhibit;

    logic        is_muldiv;
    logic        accept;
    logic [63:0] product;
    logic [31:0] quot;
    logic [31:0] rem;

    assign is_muldiv = (op >= OP_MULT) && (op <= OP_DIVU);
    assign accept    = (state == ST_IDLE) && start && !cancel && (op >= OP_MULT) && (op <= OP_MTLO);
    assign busy      = (state == ST_RUN);
    assign hilo_busy = busy | (start & is_muldiv & ~cancel);

    // Signed divide via magnitudes so 0x80000000 / -1 wraps cleanly with no trap.
    always_comb begin
        logic        sgn;
        logic [31:0] a_mag;
        logic [31:0] b_mag;
        logic [31:0] q_mag;
        logic [31:0] r_mag;
        logic [63:0] a_ext;
        logic [63:0] b_ext;
        sgn     = (op == OP_DIV) || (op == OP_MULT);
        a_ext   = {(sgn ? {32{rs_val[31]}} : 32'h0), rs_val};
        b_ext   = {(sgn ? {32{rt_val[31]}} : 32'h0), rt_val};
        product = a_ext * b_ext;
        a_mag   = (sgn && rs_val[31]) ? (32'h0 - rs_val) : rs_val;
        b_mag   = (sgn && rt_val[31]) ? (32'h0 - rt_val) : rt_val;
        q_mag   = 32'h0;
        r_mag   = 32'h0;
        if (b_mag != 32'h0) begin
            q_mag = a_mag / b_mag;
            r_mag = a_mag % b_mag;
        end
        quot = (sgn && (rs_val[31] ^ rt_val[31])) ? (32'h0 - q_mag) : q_mag;
        rem  = (sgn && rs_val[31]) ? (32'h0 - r_mag) : r_mag;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= ST_IDLE;
            cnt     <= 4'h0;
            p_hi    <= 32'h0;
            p_lo    <= 32'h0;
            inhibit <= 1'b0;
            hi      <= 32'h0;
            lo      <= 32'h0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        case (op)
                            OP_MULT, OP_MULTU: begin
                                p_hi    <= product[63:32];
                                p_lo    <= product[31:0];
                                inhibit <= 1'b0;
                                cnt     <= 4'(MULT_CYCLES - 1);
                                state   <= ST_RUN;
                            end
                            OP_DIV, OP_DIVU: begin
                                p_hi    <= rem;
                                p_lo    <= quot;
                                inhibit <= (rt_val == 32'h0);
                                cnt     <= 4'(DIV_CYCLES - 1);
                                state   <= ST_RUN;
                            end
                            OP_MTHI: hi <= rs_val;
                            OP_MTLO: lo <= rs_val;
                            default: ;
                        endcase
                    end
                end
                default: begin
                    if (cnt == 4'h0) begin
                        if (!inhibit) begin
                            hi <= p_hi;
                            lo <= p_lo;
                        end
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt - 4'h1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl against an arithmetic HI/LO model.
module tb_mdu_ctrl;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        cancel;
    logic        busy;
    logic        hilo_busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;
    int busy_starts = 0;
    logic [31:0] hi_m = 32'h0;
    logic [31:0] lo_m = 32'h0;

    mdu_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .rs_val(rs_val),
        .rt_val(rt_val), .cancel(cancel), .busy(busy), .hilo_busy(hilo_busy),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // Protocol monitor: start must never be presented while busy.
    always @(posedge clk) if (reset && start && busy) busy_starts <= busy_starts + 1;

    function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] h, output logic [31:0] l, output int n);
        longint sa, sb, sp, sq, sr;
        logic [63:0] ua, ub, up;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'h0, a};
        ub = {32'h0, b};
        h = hi_m;
        l = lo_m;
        n = 0;
        case (o)
            3'd1: begin sp = sa * sb; h = sp[63:32]; l = sp[31:0]; n = MULT_N; end
            3'd2: begin up = ua * ub; h = up[63:32]; l = up[31:0]; n = MULT_N; end
            3'd3: begin
                n = DIV_N;
                if (b != 0) begin sq = sa / sb; sr = sa % sb; l = sq[31:0]; h = sr[31:0]; end
            end
            3'd4: begin
                n = DIV_N;
                if (b != 0) begin up = ua / ub; l = up[31:0]; up = ua % ub; h = up[31:0]; end
            end
            3'd5: h = a;
            3'd6: l = a;
            default: ;
        endcase
    endfunction

    task automatic wait_idle();
        int k = 0;
        while (busy === 1'b1 && k < 40) begin @(posedge clk); #1; k++; end
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL wait_idle: busy=%b still after %0d cycles, required 0", busy, k);
        end
    endtask

    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input bit cancel_mid, input string name);
        logic [31:0] h_e, l_e;
        int n;
        wait_idle();
        model(o, a, b, h_e, l_e, n);
        start = 1'b1; op = o; rs_val = a; rt_val = b; cancel = 1'b0;
        #1;
        checks++;
        if (hilo_busy !== (n > 0)) begin
            errors++;
            $display("FAIL %s hilo_busy at issue: got %b required %b", name, hilo_busy, n > 0);
        end
        @(posedge clk); #1;
        start = 1'b0; op = 3'd0;
        for (int i = 0; i < n; i++) begin
            cancel = cancel_mid && (i == 2);
            #1;
            checks++;
            if (busy !== 1'b1 || hilo_busy !== 1'b1 || hi !== hi_m || lo !== lo_m) begin
                errors++;
                $display("FAIL %s run cycle %0d: busy=%b hilo_busy=%b hi=%h lo=%h required 1 1 %h %h",
                         name, i, busy, hilo_busy, hi, lo, hi_m, lo_m);
            end
            @(posedge clk); #1;
        end
        cancel = 1'b0;
        hi_m = h_e;
        lo_m = l_e;
        checks++;
        if (busy !== 1'b0 || hi !== hi_m || lo !== lo_m) begin
            errors++;
            $display("FAIL %s result: busy=%b hi=%h lo=%h required 0 %h %h",
                     name, busy, hi, lo, hi_m, lo_m);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b1; op = 3'd1; rs_val = 32'h7; rt_val = 32'h9; cancel = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1; start = 1'b0; op = 3'd0;
        #1;
        checks++;
        if (busy !== 1'b0 || hilo_busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            errors++;
            $display("FAIL reset: busy=%b hilo_busy=%b hi=%h lo=%h required 0 0 0 0",
                     busy, hilo_busy, hi, lo);
        end
    endtask

    task automatic test_directed();
        run_op(3'd1, 32'hFFFFFFFE, 32'd3, 1'b0, "mult");
        checks++;
        if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFA) begin
            errors++; $display("FAIL mult_const: hi=%h lo=%h required ffffffff fffffffa", hi, lo);
        end
        run_op(3'd2, 32'hFFFFFFFE, 32'd3, 1'b0, "multu");
        checks++;
        if (hi !== 32'h00000002 || lo !== 32'hFFFFFFFA) begin
            errors++; $display("FAIL multu_const: hi=%h lo=%h required 00000002 fffffffa", hi, lo);
        end
        run_op(3'd3, 32'hFFFFFFF9, 32'd2, 1'b0, "div");
        checks++;
        if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin
            errors++; $display("FAIL div_const: hi=%h lo=%h required ffffffff fffffffd", hi, lo);
        end
        run_op(3'd4, 32'd7, 32'd0, 1'b0, "divu_by_zero");
        run_op(3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, "div_overflow");
        checks++;
        if (hi !== 32'h0 || lo !== 32'h80000000) begin
            errors++; $display("FAIL div_overflow_const: hi=%h lo=%h required 0 80000000", hi, lo);
        end
    endtask

    task automatic test_cancel();
        wait_idle();
        start = 1'b1; op = 3'd1; rs_val = 32'h1234; rt_val = 32'h10; cancel = 1'b1;
        #1;
        checks++;
        if (hilo_busy !== 1'b0) begin
            errors++; $display("FAIL cancel hilo_busy: got %b required 0", hilo_busy);
        end
        @(posedge clk); #1;
        start = 1'b0; op = 3'd0; cancel = 1'b0;
        checks++;
        if (busy !== 1'b0 || hi !== hi_m || lo !== lo_m) begin
            errors++;
            $display("FAIL cancel blocked: busy=%b hi=%h lo=%h required 0 %h %h", busy, hi, lo, hi_m, lo_m);
        end
        run_op(3'd3, 32'd100, 32'd7, 1'b1, "cancel_mid_run");
    endtask

    task automatic test_move();
        run_op(3'd5, 32'h12345678, 32'h0, 1'b0, "mthi");
        run_op(3'd6, 32'hCAFEBABE, 32'h0, 1'b0, "mtlo");
        checks++;
        if (hi !== 32'h12345678 || lo !== 32'hCAFEBABE) begin
            errors++; $display("FAIL move_const: hi=%h lo=%h required 12345678 cafebabe", hi, lo);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] h1, l1, h2, l2;
        int n1, n2, base, seen;
        bit fell;
        wait_idle();
        base = busy_starts;
        model(3'd1, 32'h00010003, 32'hFFFF0002, h1, l1, n1);
        start = 1'b1; op = 3'd1; rs_val = 32'h00010003; rt_val = 32'hFFFF0002; cancel = 1'b0;
        @(posedge clk); #1;
        op = 3'd4; rs_val = 32'd1000; rt_val = 32'd33;
        seen = 0;
        fell = 1'b0;
        for (int i = 0; i < 20 && !fell; i++) begin
            if (busy === 1'b1) begin seen++; @(posedge clk); #1; end
            else fell = 1'b1;
        end
        hi_m = h1; lo_m = l1;
        checks++;
        if (seen != n1 || hi !== hi_m || lo !== lo_m || hilo_busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b first: busy_cycles=%0d hi=%h lo=%h hilo_busy=%b required %0d %h %h 1",
                     seen, hi, lo, hilo_busy, n1, hi_m, lo_m);
        end
        model(3'd4, 32'd1000, 32'd33, h2, l2, n2);
        @(posedge clk); #1;
        start = 1'b0; op = 3'd0;
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL b2b second accept: busy=%b required 1", busy);
        end
        wait_idle();
        hi_m = h2; lo_m = l2;
        checks++;
        if (hi !== hi_m || lo !== lo_m) begin
            errors++; $display("FAIL b2b second: hi=%h lo=%h required %h %h", hi, lo, hi_m, lo_m);
        end
        checks++;
        if (busy_starts - base != n1) begin
            errors++;
            $display("FAIL b2b monitor: starts_while_busy=%0d required %0d", busy_starts - base, n1);
        end
    endtask

    task automatic test_random();
        logic [2:0]  o;
        logic [31:0] a, b;
        for (int t = 0; t < 24; t++) begin
            o = 3'($urandom_range(1, 6));
            a = $urandom;
            b = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
            if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(16, 31);
            run_op(o, a, b, $urandom_range(0, 1) == 1, "random");
        end
    endtask

    task automatic test_reset_mid_run();
        wait_idle();
        start = 1'b1; op = 3'd3; rs_val = 32'd50; rt_val = 32'd3; cancel = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; op = 3'd0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        hi_m = 32'h0; lo_m = 32'h0;
        checks++;
        if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_run: busy=%b hi=%h lo=%h required 0 0 0", busy, hi, lo);
        end
        repeat (12) @(posedge clk);
        #1;
        checks++;
        if (hi !== 32'h0 || lo !== 32'h0) begin
            errors++; $display("FAIL reset_discard: hi=%h lo=%h required 0 0", hi, lo);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_cancel();
        test_move();
        test_random();
        checks++;
        if (busy_starts != 0) begin
            errors++; $display("FAIL monitor_clean: starts_while_busy=%0d required 0", busy_starts);
        end
        test_back_to_back();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
